vco_afc_ctrl: RTL and testbench

//  Automatic frequency calibration (AFC) sequencer for the VCO coarse band select (cfs).

---
 rtl/afc_pkg.sv | 15 +
 rtl/afc_win_counter.sv | 53 +++++
 rtl/vco_afc_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_vco_afc_ctrl.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/afc_pkg.sv
// rtl/afc_pkg.sv - shared state encoding and default widths for the VCO AFC sequencer
package afc_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SETTLE  = 3'd1,
      MEASURE = 3'd2,
      DECIDE  = 3'd3,
      DONE    = 3'd4
   } afc_state_e;

   localparam int CFS_W_DEF = 6;
   localparam int CNT_W_DEF = 16;

endpackage

// File: rtl/afc_win_counter.sv
// rtl/afc_win_counter.sv - settle/window timer plus saturating divided-VCO tick counter
module afc_win_counter #(
   parameter int CNT_W      = 16,
   parameter int WIN_CYC    = 256,
   parameter int SETTLE_CYC = 64
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_clear,
   input  logic             i_run,
   input  logic             i_count_en,
   input  logic             i_div_tick,
   output logic [CNT_W-1:0] o_count,
   output logic             o_settled,
   output logic             o_expired
);

   // One timer spans settle and window back to back, so a single clear per trial suffices.
   localparam int TW = $clog2(SETTLE_CYC + WIN_CYC + 1);
   localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_CYC - 1);
   localparam logic [TW-1:0] WIN_LAST    = TW'(SETTLE_CYC + WIN_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   logic [TW-1:0]    r_timer;
   logic [CNT_W-1:0] r_count;

   // Timer advances while running; clear restarts it at the start of each trial.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_timer <= '0;
      end else if (i_clear) begin
         r_timer <= '0;
      end else if (i_run) begin
         r_timer <= r_timer + 1'b1;
      end
   end

   // Tick counter saturates at all-ones instead of wrapping.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_count_en && i_div_tick && (r_count != CNT_MAX)) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign o_count   = r_count;
   assign o_settled = (r_timer == SETTLE_LAST);
   assign o_expired = (r_timer == WIN_LAST);

endmodule

// File: rtl/vco_afc_ctrl.sv
// rtl/vco_afc_ctrl.sv - VCO coarse band binary-search calibration FSM; optional AFC_TRACK_EN tracking
module vco_afc_ctrl
   import afc_pkg::*;
#(
   parameter int CFS_W      = CFS_W_DEF,
   parameter int CNT_W      = CNT_W_DEF,
   parameter int WIN_CYC    = 256,
   parameter int SETTLE_CYC = 64,
   parameter int TOL        = 2
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_start,
   input  logic [CNT_W-1:0] i_target_cnt,
   input  logic             i_div_tick,
   output logic [CFS_W-1:0] o_cfs,
   output logic             o_vctrl_hold,
   output logic             o_busy,
   output logic             o_done,
   output logic [CNT_W-1:0] o_cnt_last
);

   localparam int IW = (CFS_W > 1) ? $clog2(CFS_W) : 1;
   localparam logic [CFS_W-1:0] CFS_MID = CFS_W'(1) << (CFS_W - 1);
   localparam logic [IW-1:0]    IDX_TOP = IW'(CFS_W - 1);

   afc_state_e       r_state, w_state_nxt;
   logic [CFS_W-1:0] r_cfs, w_cfs_nxt;
   logic [IW-1:0]    r_idx, w_idx_nxt;
   logic             r_busy, w_busy_nxt;
   logic             r_hold, w_hold_nxt;
   logic             r_done, w_done_nxt;
   logic [CNT_W-1:0] r_cnt_last, w_cnt_last_nxt;
   logic             w_clear, w_run, w_count_en, w_start_ok;
   logic [CNT_W-1:0] w_count;
   logic             w_settled, w_expired;
`ifdef AFC_TRACK_EN
   logic             r_track, w_track_nxt;
   logic [CNT_W:0]   w_cnt_ext, w_tgt_ext, w_tol_ext;
`endif

   afc_win_counter #(
      .CNT_W      (CNT_W),
      .WIN_CYC    (WIN_CYC),
      .SETTLE_CYC (SETTLE_CYC)
   ) u_win_counter (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_clear    (w_clear),
      .i_run      (w_run),
      .i_count_en (w_count_en),
      .i_div_tick (i_div_tick),
      .o_count    (w_count),
      .o_settled  (w_settled),
      .o_expired  (w_expired)
   );

`ifdef AFC_TRACK_EN
   assign w_cnt_ext = {1'b0, w_count};
   assign w_tgt_ext = {1'b0, i_target_cnt};
   assign w_tol_ext = (CNT_W+1)'(TOL);
`endif

   // State and search registers; reset abandons any calibration in progress.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state    <= IDLE;
         r_cfs      <= CFS_MID;
         r_idx      <= IDX_TOP;
         r_busy     <= 1'b0;
         r_hold     <= 1'b0;
         r_done     <= 1'b0;
         r_cnt_last <= '0;
`ifdef AFC_TRACK_EN
         r_track    <= 1'b0;
`endif
      end else begin
         r_state    <= w_state_nxt;
         r_cfs      <= w_cfs_nxt;
         r_idx      <= w_idx_nxt;
         r_busy     <= w_busy_nxt;
         r_hold     <= w_hold_nxt;
         r_done     <= w_done_nxt;
         r_cnt_last <= w_cnt_last_nxt;
`ifdef AFC_TRACK_EN
         r_track    <= w_track_nxt;
`endif
      end
   end

   // Next-state, search decisions and timer control.
   always_comb begin
      w_state_nxt    = r_state;
      w_cfs_nxt      = r_cfs;
      w_idx_nxt      = r_idx;
      w_busy_nxt     = r_busy;
      w_hold_nxt     = r_hold;
      w_done_nxt     = r_done;
      w_cnt_last_nxt = r_cnt_last;
      w_clear        = 1'b0;
      w_run          = 1'b0;
      w_count_en     = 1'b0;
      w_start_ok     = i_start && ((r_state == IDLE) || (r_state == DONE));
`ifdef AFC_TRACK_EN
      w_track_nxt    = r_track;
      // While tracking, the block is not busy and a start restarts the search.
      if (i_start && r_track) begin
         w_start_ok = 1'b1;
      end
`endif

      case (r_state)
         SETTLE: begin
            w_run = 1'b1;
            if (w_settled) begin
               w_state_nxt = MEASURE;
            end
         end
         MEASURE: begin
            w_run      = 1'b1;
            w_count_en = 1'b1;
            if (w_expired) begin
               w_state_nxt = DECIDE;
            end
         end
         DECIDE: begin
            w_cnt_last_nxt = w_count;
`ifdef AFC_TRACK_EN
            if (r_track) begin
               if (w_cnt_ext > (w_tgt_ext + w_tol_ext)) begin
                  if (r_cfs != '0) begin
                     w_cfs_nxt = r_cfs - 1'b1;
                  end
               end else if ((w_cnt_ext + w_tol_ext) < w_tgt_ext) begin
                  if (r_cfs != '1) begin
                     w_cfs_nxt = r_cfs + 1'b1;
                  end
               end
               w_state_nxt = SETTLE;
               w_clear     = 1'b1;
            end else begin
`endif
            // Too fast: this band bit overshoots, drop it.
            if (w_count > i_target_cnt) begin
               w_cfs_nxt[r_idx] = 1'b0;
            end
            if (r_idx != '0) begin
               w_cfs_nxt[r_idx - 1'b1] = 1'b1;
               w_idx_nxt   = r_idx - 1'b1;
               w_state_nxt = SETTLE;
               w_clear     = 1'b1;
            end else begin
               w_busy_nxt  = 1'b0;
               w_hold_nxt  = 1'b0;
               w_done_nxt  = 1'b1;
`ifdef AFC_TRACK_EN
               w_state_nxt = SETTLE;
               w_track_nxt = 1'b1;
               w_clear     = 1'b1;
`else
               w_state_nxt = DONE;
`endif
            end
`ifdef AFC_TRACK_EN
            end
`endif
         end
         default: begin
         end
      endcase

      if (w_start_ok) begin
         w_state_nxt = SETTLE;
         w_idx_nxt   = IDX_TOP;
         w_cfs_nxt   = CFS_MID;
         w_busy_nxt  = 1'b1;
         w_hold_nxt  = 1'b1;
         w_done_nxt  = 1'b0;
         w_clear     = 1'b1;
         w_run       = 1'b0;
         w_count_en  = 1'b0;
`ifdef AFC_TRACK_EN
         w_track_nxt = 1'b0;
`endif
      end
   end

   assign o_cfs        = r_cfs;
   assign o_vctrl_hold = r_hold;
   assign o_busy       = r_busy;
   assign o_done       = r_done;
   assign o_cnt_last   = r_cnt_last;

endmodule

// File: tb/tb_vco_afc_ctrl.sv
// tb/tb_vco_afc_ctrl.sv - directed self-checking bench for vco_afc_ctrl
module tb_vco_afc_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [15:0] target = 16'd0;
   logic        div_tick = 1'b0;
   logic [5:0]  cfs;
   logic        hold;
   logic        busy;
   logic        done;
   logic [15:0] cnt_last;

   int errors = 0;
   int checks = 0;
   int tick_off = 10;
   bit force_hi = 1'b0;
   int acc = 0;
   int lat;
   logic [5:0] trial [6];
   logic rec_busy, rec_hold, rec_done;

   vco_afc_ctrl dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_start      (start),
      .i_target_cnt (target),
      .i_div_tick   (div_tick),
      .o_cfs        (cfs),
      .o_vctrl_hold (hold),
      .o_busy       (busy),
      .o_done       (done),
      .o_cnt_last   (cnt_last)
   );

   always #5 clk = ~clk;

   // VCO model: 4*cfs+tick_off evenly spaced ticks per 256-cycle window
   always @(negedge clk) begin
      int n;
      n = force_hi ? 256 : (4 * int'(cfs) + tick_off);
      if (n > 256) n = 256;
      acc = acc + n;
      if (acc >= 256) begin
         div_tick = 1'b1;
         acc = acc - 256;
      end else begin
         div_tick = 1'b0;
      end
   end

   task automatic run_search(input logic [15:0] tgt, input int poke_at);
      int n;
      n = 0;
      lat = 0;
      target = tgt;
      for (int k = 0; k < 6; k++) trial[k] = 6'h3f;
      start = 1'b1;
      while (lat == 0 && n < 3000) begin
         @(posedge clk);
         n++;
         #1;
         start = 1'b0;
         if (n == poke_at) start = 1'b1;
         if (n == 2) begin
            rec_busy = busy;
            rec_hold = hold;
            rec_done = done;
         end
         if ((n % 321) == 2 && (n / 321) < 6) trial[n / 321] = cfs;
         if (done) lat = n;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #12;
      checks++; if (cfs !== 6'd32)       begin errors++; $display("FAIL reset_cfs got=%0d exp=32", cfs); end
      checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (done !== 1'b0)       begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
      checks++; if (hold !== 1'b0)       begin errors++; $display("FAIL reset_hold got=%b exp=0", hold); end
      checks++; if (cnt_last !== 16'd0)  begin errors++; $display("FAIL reset_cnt_last got=%0d exp=0", cnt_last); end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_mid_target();
      run_search(16'd138, 0);
      checks++; if (lat !== 1927)        begin errors++; $display("FAIL t138_latency got=%0d exp=1927", lat); end
      checks++; if (cfs !== 6'd32)       begin errors++; $display("FAIL t138_cfs got=%0d exp=32", cfs); end
      checks++; if (cnt_last !== 16'd142) begin errors++; $display("FAIL t138_cnt_last got=%0d exp=142", cnt_last); end
      checks++; if (busy !== 1'b0 || hold !== 1'b0) begin errors++; $display("FAIL t138_idle_flags got busy=%b hold=%b exp 0 0", busy, hold); end
      checks++; if (rec_busy !== 1'b1 || rec_hold !== 1'b1 || rec_done !== 1'b0) begin
         errors++; $display("FAIL t138_run_flags got busy=%b hold=%b done=%b exp 1 1 0", rec_busy, rec_hold, rec_done);
      end
   endtask

   task automatic test_trial_sequence();
      logic [5:0] exp_tr [6];
      exp_tr = '{6'd32, 6'd48, 6'd40, 6'd44, 6'd46, 6'd47};
      run_search(16'd200, 0);
      for (int k = 0; k < 6; k++) begin
         checks++;
         if (trial[k] !== exp_tr[k]) begin errors++; $display("FAIL t200_trial%0d got=%0d exp=%0d", k, trial[k], exp_tr[k]); end
      end
      checks++; if (cfs !== 6'd47)       begin errors++; $display("FAIL t200_cfs got=%0d exp=47", cfs); end
      checks++; if (cnt_last !== 16'd198) begin errors++; $display("FAIL t200_cnt_last got=%0d exp=198", cnt_last); end
      checks++; if (done !== 1'b1)       begin errors++; $display("FAIL t200_done got=%b exp=1", done); end
   endtask

   task automatic test_extremes();
      run_search(16'd5, 0);
      checks++; if (cfs !== 6'd0)        begin errors++; $display("FAIL t5_cfs got=%0d exp=0", cfs); end
      checks++; if (cnt_last !== 16'd14) begin errors++; $display("FAIL t5_cnt_last got=%0d exp=14", cnt_last); end
      run_search(16'd65535, 0);
      checks++; if (cfs !== 6'd63)       begin errors++; $display("FAIL tmax_cfs got=%0d exp=63", cfs); end
      checks++; if (lat !== 1927)        begin errors++; $display("FAIL tmax_latency got=%0d exp=1927", lat); end
      force_hi = 1'b1;
      run_search(16'd0, 0);
      force_hi = 1'b0;
      checks++; if (cnt_last !== 16'd256) begin errors++; $display("FAIL tick_high_cnt got=%0d exp=256", cnt_last); end
      checks++; if (cfs !== 6'd0)        begin errors++; $display("FAIL tick_high_cfs got=%0d exp=0", cfs); end
   endtask

   task automatic test_back_to_back();
      run_search(16'd200, 500);
      checks++; if (lat !== 1927)        begin errors++; $display("FAIL busy_start_latency got=%0d exp=1927", lat); end
      checks++; if (cfs !== 6'd47)       begin errors++; $display("FAIL busy_start_cfs got=%0d exp=47", cfs); end
      checks++; if (trial[2] !== 6'd40 || trial[5] !== 6'd47) begin
         errors++; $display("FAIL busy_start_trials got=%0d,%0d exp=40,47", trial[2], trial[5]);
      end
   endtask

   task automatic test_async_reset();
      target = 16'd138;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (164) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      checks++; if (cfs !== 6'd32 || busy !== 1'b0 || done !== 1'b0 || hold !== 1'b0 || cnt_last !== 16'd0) begin
         errors++; $display("FAIL async_reset got cfs=%0d busy=%b done=%b hold=%b cnt=%0d exp 32 0 0 0 0", cfs, busy, done, hold, cnt_last);
      end
      @(posedge clk);
      #1;
      checks++; if (busy !== 1'b0 || cfs !== 6'd32) begin
         errors++; $display("FAIL async_reset_hold got busy=%b cfs=%0d exp 0 32", busy, cfs);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

`ifdef AFC_TRACK_EN
   task automatic test_track();
      bit done_dropped;
      done_dropped = 1'b0;
      tick_off = 10;
      run_search(16'd138, 0);
      checks++; if (cfs !== 6'd32) begin errors++; $display("FAIL track_lock_cfs got=%0d exp=32", cfs); end
      tick_off = 18;
      for (int c = 0; c < 4 * 321; c++) begin
         @(posedge clk);
         #1;
         if (done !== 1'b1) done_dropped = 1'b1;
      end
      checks++; if (cfs !== 6'd30) begin errors++; $display("FAIL track_cfs got=%0d exp=30", cfs); end
      checks++; if (done_dropped)  begin errors++; $display("FAIL track_done got=dropped exp=held_high"); end
      checks++; if (hold !== 1'b0) begin errors++; $display("FAIL track_hold got=%b exp=0", hold); end
      tick_off = 10;
   endtask
`endif

   initial begin
      test_reset();
      test_mid_target();
      test_trial_sequence();
      test_extremes();
      test_back_to_back();
      test_async_reset();
`ifdef AFC_TRACK_EN
      test_track();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
